// File: rtl/Counter_redirect_pkg.sv
// Shared types for the PC-redirect sequencer: clock/reset bundle, redirect
// rank ordering and the default exception vector.
package Counter_redirect_pkg;

  // Clock/reset bundle; reset is synchronous and active-high.
  typedef struct packed {
    logic clk;
    logic rst;
  } Util_Control_T;

  // Numeric order of the encoding is the priority order (higher wins).
  typedef enum logic [1:0] {
    RANK_NONE = 2'd0,
    RANK_BR   = 2'd1,
    RANK_JR   = 2'd2,
    RANK_EXC  = 2'd3
  } redirect_rank_t;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

endpackage

// File: rtl/counter_flush_timer.sv
// Loadable down-counter that times the flush window after a redirect issue.
// Loads DELAY+1, counts down while dec_i is high, flags nonzero.
module counter_flush_timer #(
  parameter int DELAY = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic nonzero_o
);

  localparam int CNT_W = $clog2(DELAY + 2);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DELAY + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign nonzero_o = (cnt_q != '0);

  // Reload wins over decrement so a new issue inside a window restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (dec_i && nonzero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_redirect_ctrl.sv
// PC-redirect sequencer feeding the program-counter counter. Ranks branch,
// register-jump and exception requests, holds the winner across stalls,
// drives the counter's d/load/enable and opens a flush window after issue.
module counter_redirect_ctrl
  import Counter_redirect_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          DELAY      = 0,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  Util_Control_T    ctrl,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jr_valid,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] cnt_d,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic             flush,
  output logic             busy
);

  localparam logic [WIDTH-1:0] EXC_TGT = WIDTH'(EXC_VECTOR);

  typedef struct packed {
    redirect_rank_t   rank;
    logic [WIDTH-1:0] target;
  } redirect_req_t;

  logic clk;
  logic rst;
  assign clk = ctrl.clk;
  assign rst = ctrl.rst;

  redirect_req_t  req;
  redirect_rank_t pend_rank_q, pend_rank_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic issue;

  // Highest-ranked incoming request; branch/jump are wrong-path while flushing.
  always_comb begin
    req.rank   = RANK_NONE;
    req.target = '0;
    if (exc_valid) begin
      req.rank   = RANK_EXC;
      req.target = EXC_TGT;
    end else if (jr_valid && !flush) begin
      req.rank   = RANK_JR;
      req.target = jr_target;
    end else if (br_valid && !flush) begin
      req.rank   = RANK_BR;
      req.target = br_target;
    end
  end

  assign busy       = (pend_rank_q != RANK_NONE);
  assign issue      = busy && !stall;
  assign cnt_load   = issue;
  assign cnt_d      = busy ? pend_tgt_q : '0;
  assign cnt_enable = !stall && !cnt_load && !rst;

  // Pending update: strictly-higher rank replaces, otherwise clear on issue.
  always_comb begin
    pend_rank_d = pend_rank_q;
    pend_tgt_d  = pend_tgt_q;
    if (req.rank > pend_rank_q) begin
      pend_rank_d = req.rank;
      pend_tgt_d  = req.target;
    end else if (issue) begin
      pend_rank_d = RANK_NONE;
    end
  end

  // Pending rank is control state and is reset; it also qualifies the target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rank_q <= RANK_NONE;
    end else begin
      pend_rank_q <= pend_rank_d;
    end
  end

  // Pending target is pure data, only meaningful while the rank is valid.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  counter_flush_timer #(
    .DELAY (DELAY)
  ) u_flush_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (issue),
    .dec_i     (!stall),
    .nonzero_o (flush)
  );

endmodule

// File: tb/tb_counter_redirect_ctrl.sv
// Bench for counter_redirect_ctrl: two instances (DELAY=0 and DELAY=2) share
// stimulus; directed scenarios plus random traffic against a reference model.
module tb_counter_redirect_ctrl;
  import Counter_redirect_pkg::*;

  localparam logic [31:0] EXC = 32'h8000_0180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic br_valid = 1'b0, jr_valid = 1'b0, exc_valid = 1'b0;
  logic [31:0] br_target = '0, jr_target = '0;
  Util_Control_T ctrl;

  assign ctrl.clk = clk;
  assign ctrl.rst = rst;

  always #5 clk = ~clk;

  logic [31:0] o_d    [2];
  logic        o_load [2];
  logic        o_en   [2];
  logic        o_fl   [2];
  logic        o_busy [2];

  counter_redirect_ctrl #(.WIDTH(32), .DELAY(0), .EXC_VECTOR(EXC)) u_d0 (
    .ctrl(ctrl), .stall(stall),
    .br_valid(br_valid), .br_target(br_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .exc_valid(exc_valid),
    .cnt_d(o_d[0]), .cnt_load(o_load[0]), .cnt_enable(o_en[0]),
    .flush(o_fl[0]), .busy(o_busy[0])
  );

  counter_redirect_ctrl #(.WIDTH(32), .DELAY(2), .EXC_VECTOR(EXC)) u_d2 (
    .ctrl(ctrl), .stall(stall),
    .br_valid(br_valid), .br_target(br_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .exc_valid(exc_valid),
    .cnt_d(o_d[1]), .cnt_load(o_load[1]), .cnt_enable(o_en[1]),
    .flush(o_fl[1]), .busy(o_busy[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending slot as (priority number, target), flush as
  // number of remaining unstalled cycles.
  int          m_pri  [2];
  logic [31:0] m_tgt  [2];
  int          m_left [2];
  int          m_dly  [2] = '{0, 2};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the model, then advance the model to the next cycle.
  task automatic step(input bit r, input bit s,
                      input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt,
                      input bit e);
    @(negedge clk);
    rst = r; stall = s;
    br_valid = b; br_target = bt;
    jr_valid = j; jr_target = jt;
    exc_valid = e;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit          x_load;
      int          np;
      logic [31:0] nt;
      x_load = (m_pri[k] != 0) && !s;
      check(k == 0 ? "d0.load"  : "d2.load",  64'(o_load[k]), 64'(x_load));
      check(k == 0 ? "d0.cnt_d" : "d2.cnt_d", 64'(o_d[k]), 64'((m_pri[k] != 0) ? m_tgt[k] : 32'h0));
      check(k == 0 ? "d0.en"    : "d2.en",    64'(o_en[k]), 64'(!s && !x_load && !r));
      check(k == 0 ? "d0.flush" : "d2.flush", 64'(o_fl[k]), 64'(m_left[k] > 0));
      check(k == 0 ? "d0.busy"  : "d2.busy",  64'(o_busy[k]), 64'(m_pri[k] != 0));
      // Model advance
      np = 0; nt = '0;
      if (e)                          begin np = 3; nt = EXC; end
      else if (j && m_left[k] == 0)   begin np = 2; nt = jt;  end
      else if (b && m_left[k] == 0)   begin np = 1; nt = bt;  end
      if (r) begin
        m_pri[k] = 0; m_left[k] = 0;
      end else begin
        if (x_load)                      m_left[k] = m_dly[k] + 1;
        else if (!s && m_left[k] > 0)    m_left[k] = m_left[k] - 1;
        if (np > m_pri[k])      begin m_pri[k] = np; m_tgt[k] = nt; end
        else if (x_load)        m_pri[k] = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pri[k] = 0; m_tgt[k] = '0; m_left[k] = 0;
    end
    // Reset cycles: only enable has a known value before the first edge,
    // so compare just that before the model is meaningful.
    @(negedge clk); #1;
    check("rst.en0", 64'(o_en[0]), 64'(0));
    check("rst.en2", 64'(o_en[1]), 64'(0));
    step(1, 0, 0, '0, 0, '0, 0);

    // Idle after reset
    step(0, 0, 0, '0, 0, '0, 0);
    check("idle.en",   64'(o_en[0]), 64'(1));
    check("idle.d",    64'(o_d[0]),  64'(0));
    check("idle.busy", 64'(o_busy[0]), 64'(0));

    // Branch 0x400, DELAY=0 instance
    step(0, 0, 1, 32'h400, 0, '0, 0);
    step(0, 0, 0, '0, 0, '0, 0);
    check("br.load", 64'(o_load[0]), 64'(1));
    check("br.d",    64'(o_d[0]),    64'(32'h400));
    check("br.en",   64'(o_en[0]),   64'(0));
    step(0, 0, 0, '0, 0, '0, 0);
    check("br.flush", 64'(o_fl[0]),   64'(1));
    check("br.busy",  64'(o_busy[0]), 64'(0));
    step(0, 0, 0, '0, 0, '0, 0);
    check("br.flush_end", 64'(o_fl[0]), 64'(0));
    idle(3);

    // Simultaneous jump and branch
    step(0, 0, 1, 32'h200, 1, 32'h100, 0);
    step(0, 0, 0, '0, 0, '0, 0);
    check("jrbr.d", 64'(o_d[0]), 64'(32'h100));
    idle(4);

    // Branch held across stall, exception overrides during stall
    step(0, 0, 1, 32'h200, 0, '0, 0);
    step(0, 1, 0, '0, 0, '0, 0);
    check("stall.load", 64'(o_load[0]), 64'(0));
    step(0, 1, 0, '0, 0, '0, 1);
    step(0, 1, 0, '0, 0, '0, 0);
    check("stall.load2", 64'(o_load[0]), 64'(0));
    step(0, 0, 0, '0, 0, '0, 0);
    check("exc.load", 64'(o_load[0]), 64'(1));
    check("exc.d",    64'(o_d[0]),    64'(EXC));
    step(0, 0, 0, '0, 0, '0, 0);
    check("exc.once", 64'(o_load[0]), 64'(0));
    idle(4);

    // DELAY=2 instance: window of 3, branch ignored, exception reloads
    step(0, 0, 0, '0, 1, 32'h300, 0);
    step(0, 0, 0, '0, 0, '0, 0);
    check("d2.jr.load", 64'(o_load[1]), 64'(1));
    step(0, 0, 1, 32'h999, 0, '0, 0);
    check("d2.win1", 64'(o_fl[1]), 64'(1));
    step(0, 0, 0, '0, 0, '0, 0);
    check("d2.brign", 64'(o_busy[1]), 64'(0));
    step(0, 0, 0, '0, 0, '0, 1);
    check("d2.win3", 64'(o_fl[1]), 64'(1));
    step(0, 0, 0, '0, 0, '0, 0);
    check("d2.exc.load", 64'(o_load[1]), 64'(1));
    check("d2.exc.d",    64'(o_d[1]),    64'(EXC));
    step(0, 0, 0, '0, 0, '0, 0);
    check("d2.reload", 64'(o_fl[1]), 64'(1));
    idle(4);

    // Reset while pending under stall
    step(0, 1, 1, 32'h500, 0, '0, 0);
    step(0, 1, 0, '0, 0, '0, 0);
    check("rp.busy", 64'(o_busy[0]), 64'(1));
    step(1, 1, 0, '0, 0, '0, 0);
    step(0, 0, 0, '0, 0, '0, 0);
    check("rp.busy0", 64'(o_busy[0]), 64'(0));
    check("rp.load0", 64'(o_load[0]), 64'(0));
    step(0, 0, 0, '0, 0, '0, 0);
    check("rp.noload", 64'(o_load[0]), 64'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom,
           $urandom_range(0, 4) == 0, $urandom,
           $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
